// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states,
// stall vectors, exception codes and counter widths.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_QUIET = 2'd2
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall vector bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EXC  = 6'b011111;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  // The deepest requesting stage wins; it and everything upstream stop.
  function automatic logic [5:0] stall_encode(input logic req_if,
                                              input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    logic [5:0] enc;
    if (req_mem) begin
      enc = STALL_MEM;
    end else if (req_ex) begin
      enc = STALL_EX;
    end else if (req_id) begin
      enc = STALL_ID;
    end else if (req_if) begin
      enc = STALL_IF;
    end else begin
      enc = STALL_NONE;
    end
    return enc;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall-cycle and flush-event counters. Counter flops exist only
// when PIPE_PERF_CNT_EN is defined; otherwise both outputs are tied to zero.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   stall_pc_i,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] o_stall_cycles,
  output logic [FLUSH_CNT_W-1:0] o_flush_cnt
);

`ifdef PIPE_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Next-state: increment on event, hold at all-ones
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cnt_d    = flush_cnt_q;
    if (stall_pc_i && (stall_cycles_q != {STALL_CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush_i && (flush_cnt_q != {FLUSH_CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= {STALL_CNT_W{1'b0}};
      flush_cnt_q    <= {FLUSH_CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_cnt    = flush_cnt_q;
`else
  logic unused_s;
  assign unused_s       = ^{i_clk, i_rst_n, stall_pc_i, flush_i};
  assign o_stall_cycles = {STALL_CNT_W{1'b0}};
  assign o_flush_cnt    = {FLUSH_CNT_W{1'b0}};
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: RUN -> FLUSH -> QUIET exception sequencing
// and stall priority. Performance counters are built under PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallreq_if,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_stallreq_mem,
  input  logic [31:0] i_except_type,
  input  logic [31:0] i_cp0_epc,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_flush_cnt
);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  stall_s;

  // Next-state, redirect latch and stall vector
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    stall_s  = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        if (i_except_type != EXC_NONE) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          stall_s  = STALL_EXC;
          new_pc_d = (i_except_type == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
        end else begin
          state_d  = ST_RUN;
          stall_s  = stall_encode(i_stallreq_if, i_stallreq_id,
                                  i_stallreq_ex, i_stallreq_mem);
        end
      end
      ST_FLUSH: begin
        state_d = ST_QUIET;
        stall_s = STALL_NONE;
      end
      ST_QUIET: begin
        state_d = ST_RUN;
        stall_s = stall_encode(i_stallreq_if, i_stallreq_id,
                               i_stallreq_ex, i_stallreq_mem);
      end
      default: begin
        state_d = ST_RUN;
        stall_s = STALL_NONE;
      end
    endcase
  end

  // Stall is combinational, but forced idle while reset is held
  always_comb begin
    if (!i_rst_n) begin
      o_stall = STALL_NONE;
    end else begin
      o_stall = stall_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign o_flush  = flush_q;
  assign o_new_pc = new_pc_q;

  pipe_perf_cnt u_perf_cnt (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .stall_pc_i     (o_stall[0]),
    .flush_i        (flush_q),
    .o_stall_cycles (o_stall_cycles),
    .o_flush_cnt    (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// compared against a cycle-count reference model of the exception sequence.
module tb_pipe_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem;
  logic [31:0] i_except_type, i_cp0_epc;
  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_new_pc;
  logic [31:0] o_stall_cycles;
  logic [15:0] o_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_stallreq_if  (i_stallreq_if),
    .i_stallreq_id  (i_stallreq_id),
    .i_stallreq_ex  (i_stallreq_ex),
    .i_stallreq_mem (i_stallreq_mem),
    .i_except_type  (i_except_type),
    .i_cp0_epc      (i_cp0_epc),
    .o_stall        (o_stall),
    .o_flush        (o_flush),
    .o_new_pc       (o_new_pc),
    .o_stall_cycles (o_stall_cycles),
    .o_flush_cnt    (o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // req = {mem, ex, id, if}; inputs change just after a rising edge and
  // outputs are sampled on the following falling edge.
  task automatic set_in(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    {i_stallreq_mem, i_stallreq_ex, i_stallreq_id, i_stallreq_if} = req;
    i_except_type = exc;
    i_cp0_epc     = epc;
    @(negedge i_clk);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Deepest requesting stage h (if=0..mem=3) stops PC through stage h+1.
  function automatic logic [5:0] ref_prio(input logic [3:0] req);
    int h;
    h = -1;
    for (int k = 0; k < 4; k++) if (req[k]) h = k;
    if (h < 0) return 6'b000000;
    return 6'((1 << (h + 2)) - 1);
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    set_in(4'b1111, 32'h0000_0008, 32'h0000_abcd);
    for (int c = 0; c < 2; c++) begin
      checks++; if (o_stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got=%b exp=000000", o_stall); end
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", o_flush); end
      checks++; if (o_new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", o_new_pc); end
      checks++; if (o_stall_cycles !== 32'h0 || o_flush_cnt !== 16'h0) begin
        errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", o_stall_cycles, o_flush_cnt); end
      step();
    end
    i_rst_n = 1'b1;
    set_in(4'b0000, 32'h0, 32'h0);
    checks++; if (o_stall !== 6'b000000 || o_flush !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got stall=%b flush=%b exp=000000/0", o_stall, o_flush); end
    step();
  endtask

  task automatic test_stall_priority();
    logic [3:0] reqs [6];
    logic [5:0] exps [6];
    reqs = '{4'b0011, 4'b1100, 4'b0100, 4'b0001, 4'b0000, 4'b1111};
    exps = '{6'b000111, 6'b011111, 6'b001111, 6'b000011, 6'b000000, 6'b011111};
    for (int i = 0; i < 6; i++) begin
      set_in(reqs[i], 32'h0, 32'h0);
      checks++; if (o_stall !== exps[i]) begin
        errors++; $display("FAIL stall_prio req=%b got=%b exp=%b", reqs[i], o_stall, exps[i]); end
      step();
    end
  endtask

  task automatic test_exception();
    set_in(4'b0001, 32'h0000_0008, 32'h0000_9999);
    checks++; if (o_stall !== 6'b011111) begin errors++; $display("FAIL exc_detect_stall got=%b exp=011111", o_stall); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL exc_detect_flush got=%b exp=0", o_flush); end
    step();
    set_in(4'b1111, 32'h0, 32'h0);
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b exp=1", o_flush); end
    checks++; if (o_new_pc !== 32'h0000_0020) begin errors++; $display("FAIL exc_new_pc got=%h exp=00000020", o_new_pc); end
    checks++; if (o_stall !== 6'b000000) begin errors++; $display("FAIL exc_flush_stall got=%b exp=000000", o_stall); end
    step();
    set_in(4'b1111, 32'h0, 32'h0);
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL exc_flush_end got=%b exp=0", o_flush); end
    checks++; if (o_stall !== 6'b011111) begin errors++; $display("FAIL exc_quiet_stall got=%b exp=011111", o_stall); end
    checks++; if (o_new_pc !== 32'h0000_0020) begin errors++; $display("FAIL exc_pc_hold got=%h exp=00000020", o_new_pc); end
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_eret();
    set_in(4'b0000, 32'h0000_000e, 32'h0000_1234);
    checks++; if (o_stall !== 6'b011111) begin errors++; $display("FAIL eret_stall got=%b exp=011111", o_stall); end
    step();
    set_in(4'b0000, 32'h0, 32'h0000_7777);
    checks++; if (o_flush !== 1'b1 || o_new_pc !== 32'h0000_1234) begin
      errors++; $display("FAIL eret_redirect got flush=%b pc=%h exp=1/00001234", o_flush, o_new_pc); end
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    set_in(4'b0000, 32'h0000_0008, 32'h0000_5555);
    checks++; if (o_stall !== 6'b011111) begin errors++; $display("FAIL b2b_first_detect got=%b exp=011111", o_stall); end
    step();
    for (int c = 1; c <= 3; c++) begin
      set_in(4'b0000, 32'h0000_000e, 32'h0000_5555);
      if (o_flush === 1'b1) pulses++;
      if (c == 1) begin
        checks++; if (o_new_pc !== 32'h0000_0020) begin errors++; $display("FAIL b2b_first_pc got=%h exp=00000020", o_new_pc); end
      end else if (c == 2) begin
        checks++; if (o_stall !== 6'b000000 || o_new_pc !== 32'h0000_0020) begin
          errors++; $display("FAIL b2b_quiet_ignore got stall=%b pc=%h exp=000000/00000020", o_stall, o_new_pc); end
      end else begin
        checks++; if (o_stall !== 6'b011111) begin errors++; $display("FAIL b2b_second_detect got=%b exp=011111", o_stall); end
      end
      step();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=1", pulses); end
    set_in(4'b0000, 32'h0, 32'h0);
    checks++; if (o_flush !== 1'b1 || o_new_pc !== 32'h0000_5555) begin
      errors++; $display("FAIL b2b_second_flush got flush=%b pc=%h exp=1/00005555", o_flush, o_new_pc); end
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] exp_sc;
    logic [15:0] exp_fc;
`ifdef PIPE_PERF_CNT_EN
    exp_sc = 32'd1;
    exp_fc = 16'd1;
`else
    exp_sc = 32'd0;
    exp_fc = 16'd0;
`endif
    set_in(4'b0000, 32'h0000_0008, 32'h0);
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL rmf_flush_before got=%b exp=1", o_flush); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_flush !== 1'b0 || o_new_pc !== 32'h0) begin
      errors++; $display("FAIL rmf_async_clear got flush=%b pc=%h exp=0/0", o_flush, o_new_pc); end
    step();
    i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(4'b0000, 32'h0, 32'h0);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL rmf_no_pending_flush cyc=%0d got=%b exp=0", c, o_flush); end
      step();
    end
    checks++; if (o_flush_cnt !== 16'd0 || o_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL rmf_counters_cleared got=%0d/%0d exp=0/0", o_flush_cnt, o_stall_cycles); end
    set_in(4'b0000, 32'h0000_0008, 32'h0);
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    step();
    set_in(4'b0000, 32'h0, 32'h0);
    checks++; if (o_flush_cnt !== exp_fc || o_stall_cycles !== exp_sc) begin
      errors++; $display("FAIL rmf_counters_after got=%0d/%0d exp=%0d/%0d", o_flush_cnt, o_stall_cycles, exp_fc, exp_sc); end
    step();
  endtask

  task automatic test_random();
    int          since;   // 0: accepting, 1: flush cycle, 2: quiet cycle
    logic [31:0] m_pc;
    longint      m_sc;
    int          m_fc;
    logic [3:0]  req;
    logic [31:0] exc, epc;
    logic [5:0]  exp_stall;
    int          r;
    i_rst_n = 1'b0;
    set_in(4'b0000, 32'h0, 32'h0);
    step();
    i_rst_n = 1'b1;
    since = 0; m_pc = 32'h0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom_range(0, 15));
      r   = int'($urandom_range(0, 7));
      exc = (r == 5) ? 32'h0000_0008 : (r == 6) ? 32'h0000_000e :
            (r == 7) ? ($urandom() | 32'h1) : 32'h0;
      epc = $urandom();
      set_in(req, exc, epc);
      if (since == 1) exp_stall = 6'b000000;
      else if (since == 0 && exc != 32'h0) exp_stall = 6'b011111;
      else exp_stall = ref_prio(req);
      checks++; if (o_stall !== exp_stall) begin
        errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, o_stall, exp_stall); end
      checks++; if (o_flush !== (since == 1)) begin
        errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, o_flush, (since == 1)); end
      checks++; if (o_new_pc !== m_pc) begin
        errors++; $display("FAIL rnd_new_pc n=%0d got=%h exp=%h", n, o_new_pc, m_pc); end
`ifdef PIPE_PERF_CNT_EN
      checks++; if (o_stall_cycles !== 32'(m_sc) || o_flush_cnt !== 16'(m_fc)) begin
        errors++; $display("FAIL rnd_counters n=%0d got=%0d/%0d exp=%0d/%0d", n, o_stall_cycles, o_flush_cnt, m_sc, m_fc); end
`else
      checks++; if (o_stall_cycles !== 32'd0 || o_flush_cnt !== 16'd0) begin
        errors++; $display("FAIL rnd_counters_tied n=%0d got=%0d/%0d exp=0/0", n, o_stall_cycles, o_flush_cnt); end
`endif
      if (exp_stall[0]) m_sc++;
      if (since == 1) m_fc++;
      if (since == 0 && exc != 32'h0) begin
        m_pc  = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
        since = 1;
      end else if (since == 1) begin
        since = 2;
      end else begin
        since = 0;
      end
      step();
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    {i_stallreq_mem, i_stallreq_ex, i_stallreq_id, i_stallreq_if} = 4'b0000;
    i_except_type = 32'h0;
    i_cp0_epc     = 32'h0;
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, general exception entry PC.
REQ-002 SHALL have ports: i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_stallreq_if / i_stallreq_id / i_stallreq_ex / i_stallreq_mem  in  1 each  stage stall requests.
REQ-004 SHALL have ports: i_except_type  in  32  exception code from MEM stage (0 = none); i_cp0_epc  in  32  EPC value.
REQ-005 SHALL have ports: o_stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1=STOP; o_flush  out  1  pipeline flush; o_new_pc  out  32  redirect PC.
REQ-006 SHALL have ports: o_stall_cycles  out  32  stall-cycle count; o_flush_cnt  out  16  flush-event count.

Function
REQ-007 SHALL implement FSM states RUN, FLUSH, QUIET.
REQ-008 SHALL transition from RUN to FLUSH when i_except_type != 0; FLUSH to QUIET unconditionally; QUIET to RUN unconditionally.
REQ-009 SHALL, in RUN with i_except_type != 0 (detect cycle), drive o_stall = 6'b011111 combinationally, overriding all stall requests.
REQ-010 SHALL, in RUN or QUIET without detect, drive o_stall combinationally by priority mem > ex > id > if: 6'b011111 / 6'b001111 / 6'b000111 / 6'b000011; no request gives 6'b000000.
REQ-011 SHALL latch o_new_pc at the detect-cycle edge: i_cp0_epc when i_except_type == 32'h0000_000e (eret), else EXC_VECTOR.
REQ-012 SHALL assert o_flush = 1 for exactly the single FLUSH-state cycle (registered, 1-cycle latency after detect); o_stall = 0 in FLUSH.
REQ-013 SHALL hold o_new_pc stable from the FLUSH cycle until the next latch.
REQ-014 SHALL ignore i_except_type in FLUSH and QUIET (no new detect, no new latch); stall requests in QUIET handled per REQ-010.
REQ-015 SHALL ignore all stall requests in FLUSH.
REQ-016 SHALL treat back-to-back exceptions as: earliest one taken; next acceptable only once FSM is back in RUN.

Reset
REQ-017 SHALL, on i_rst_n low at any time, go to RUN and clear o_flush=0, o_new_pc=0, o_stall_cycles=0, o_flush_cnt=0, asynchronously.
REQ-018 SHALL, during reset, drive o_stall = 6'b000000 regardless of requests.
REQ-019 SHALL, on reset mid-FLUSH, drop o_flush immediately and never emit the pending flush after release.

Configuration
REQ-020 SHALL compile performance counters only under macro PIPE_PERF_CNT_EN.
REQ-021 SHALL, with PIPE_PERF_CNT_EN, increment o_stall_cycles each cycle o_stall[0]==1 and o_flush_cnt each FLUSH cycle; both saturate at all-ones.
REQ-022 SHALL, without PIPE_PERF_CNT_EN, keep both counter ports present, tied to 0, with no counter flops.

Structure
REQ-023 SHALL place FSM state enum, stall encodings, and exception codes (ERET = 32'h0000_000e) in the shared package/defines header alongside STOP/NO_STOP.
REQ-024 SHALL keep counters in sub-module pipe_perf_cnt; FSM and stall priority remain in pipe_ctrl.

Verification
REQ-025 SHALL cover: i_stallreq_id=1 and i_stallreq_if=1 in RUN -> o_stall=6'b000111 same cycle.
REQ-026 SHALL cover: i_stallreq_mem=1 with i_stallreq_ex=1 -> o_stall=6'b011111; drop mem -> 6'b001111.
REQ-027 SHALL cover: i_except_type=32'h8 at cycle N -> o_stall=6'b011111 at N; o_flush=1, o_new_pc=32'h20 at N+1; o_flush=0 at N+2.
REQ-028 SHALL cover: i_except_type=32'he with i_cp0_epc=32'h0000_1234 -> o_new_pc=32'h0000_1234 in FLUSH cycle.
REQ-029 SHALL cover: i_except_type nonzero held for 3 cycles -> exactly one o_flush pulse; second exception only if still nonzero in RUN at N+3.
REQ-030 SHALL cover: reset asserted in FLUSH cycle -> o_flush=0 immediately; with PIPE_PERF_CNT_EN, o_flush_cnt=0 after release and counts 1 after next exception.
